// File: rtl/coord_uart_tx.sv
// coord_uart_tx: sends tracker coordinates as a fixed UART 8N1 frame.
// Frame bytes: AA 55 d1 d2 d3 d4, plus a sum byte when COORD_CSUM_EN is defined.
// A frame goes out when the inputs differ from the last sent snapshot, and
// periodically every PERIOD_CYCLES clocks (0 turns the periodic send off).
module coord_uart_tx #(
  parameter int CLK_FREQ      = 27000000,
  parameter int BAUD          = 115200,
  parameter int PERIOD_CYCLES = 27000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  input  logic [7:0] d3,
  input  logic [7:0] d4,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  // Clocks per bit and the baud counter compare points.
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] BIT_LAST = CW'(CPB - 1);
  // frame_done is registered, so it is armed one clock before the stop bit ends.
  localparam logic [CW-1:0] DONE_ARM = CW'(CPB - 2);

`ifdef COORD_CSUM_EN
  localparam int NBYTES = 7;
`else
  localparam int NBYTES = 6;
`endif
  localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state_reg, state_next;
  logic [31:0]     snap_reg, snap_next;
  logic            pending_reg, pending_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_reg, bit_next;
  logic [2:0]      idx_reg, idx_next;
  logic            tx_reg, tx_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;

  logic [31:0]     coord_live;
  logic [7:0]      frame_bytes [0:7];
  logic [7:0]      cur_byte;
  logic [2:0]      bit_inc;
  logic            launch;
  logic            coord_changed;
  logic            period_wrap;
  logic            bit_end;

  assign coord_live = {d1, d2, d3, d4};

  // Frame byte table: fixed header, snapshot bytes, optional sum, unused pad.
  assign frame_bytes[0] = 8'hAA;
  assign frame_bytes[1] = 8'h55;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_data
      assign frame_bytes[gi+2] = snap_reg[31-8*gi -: 8];
    end
    for (gi = NBYTES; gi < 8; gi++) begin : g_pad
      assign frame_bytes[gi] = 8'hFF;
    end
  endgenerate

`ifdef COORD_CSUM_EN
  assign frame_bytes[6] = snap_reg[31:24] + snap_reg[23:16] + snap_reg[15:8] + snap_reg[7:0];
`endif

  // Free-running period counter; it keeps counting while a frame is in flight.
  generate
    if (PERIOD_CYCLES == 0) begin : g_no_period
      assign period_wrap = 1'b0;
    end else begin : g_period
      localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
      localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYCLES - 1);
      logic [PW-1:0] per_reg;
      assign period_wrap = (per_reg == PER_LAST);
      // Period counter: 0..PERIOD_CYCLES-1, wrapping raises a send request.
      always_ff @(posedge clk) begin
        if (rst) begin
          per_reg <= '0;
        end else if (period_wrap) begin
          per_reg <= '0;
        end else begin
          per_reg <= per_reg + PW'(1);
        end
      end
    end
  endgenerate

  // On the launch edge the snapshot takes the live value, so compare against
  // that instead of the stale snapshot to avoid a spurious repeat frame.
  assign launch        = (state_reg == S_IDLE) && pending_reg;
  assign coord_changed = !launch && (coord_live != snap_reg);
  assign cur_byte      = frame_bytes[idx_reg];
  assign bit_inc       = bit_reg + 3'd1;
  assign bit_end       = (cnt_reg == BIT_LAST);

  // Next-state and registered-output logic for the frame/byte sequencer.
  always_comb begin
    state_next   = state_reg;
    snap_next    = snap_reg;
    cnt_next     = cnt_reg;
    bit_next     = bit_reg;
    idx_next     = idx_reg;
    tx_next      = tx_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;

    // Triggers set pending once; a trigger on the launch edge wins over the clear.
    if (coord_changed || period_wrap) begin
      pending_next = 1'b1;
    end else if (launch) begin
      pending_next = 1'b0;
    end else begin
      pending_next = pending_reg;
    end

    case (state_reg)
      S_IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        cnt_next  = '0;
        if (pending_reg) begin
          snap_next  = coord_live;
          idx_next   = '0;
          bit_next   = '0;
          state_next = S_START;
          busy_next  = 1'b1;
          tx_next    = 1'b0;
        end
      end
      S_START: begin
        cnt_next = bit_end ? '0 : cnt_reg + CW'(1);
        if (bit_end) begin
          state_next = S_DATA;
          bit_next   = '0;
          tx_next    = cur_byte[0];
        end
      end
      S_DATA: begin
        cnt_next = bit_end ? '0 : cnt_reg + CW'(1);
        if (bit_end) begin
          if (bit_reg == 3'd7) begin
            state_next = S_STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next = bit_inc;
            tx_next  = cur_byte[bit_inc];
          end
        end
      end
      S_STOP: begin
        cnt_next  = bit_end ? '0 : cnt_reg + CW'(1);
        done_next = (idx_reg == LAST_IDX) && (cnt_reg == DONE_ARM);
        if (bit_end) begin
          if (idx_reg == LAST_IDX) begin
            state_next = S_IDLE;
            busy_next  = 1'b0;
            tx_next    = 1'b1;
          end else begin
            idx_next   = idx_reg + 3'd1;
            state_next = S_START;
            tx_next    = 1'b0;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Sequencer state and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      snap_reg    <= '0;
      pending_reg <= 1'b0;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      idx_reg     <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      snap_reg    <= snap_next;
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      idx_reg     <= idx_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign tx         = tx_reg;
  assign busy       = busy_reg;
  assign frame_done = done_reg;

endmodule
